dot_accum_int: RTL and testbench



---
 rtl/dot_accum_int_if.sv | 23 ++
 rtl/dot_accum_int.sv | 111 +++++++++++
 tb/tb_dot_accum_int.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/dot_accum_int_if.sv
// Stream bundle around the dot-product accumulator: partial sums in, requantised results out.
// The slave side is the accumulator; the master side is whatever surrounds it.
interface dot_accum_int_if #(
    parameter int bitw = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [bitw-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [bitw-1:0] out_data;
    logic            out_sat;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/dot_accum_int.sv
// Sums nchunk signed partial dot products with a saturating accumulator, then applies
// shift, optional ReLU and clipping to bitw bits, and offers the result on valid/ready.
module dot_accum_int #(
    parameter int bitw   = 8,
    parameter int accw   = 16,
    parameter int nchunk = 4,
    parameter int shift  = 0,
    parameter int relu   = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    dot_accum_int_if.slave      bus
);
    localparam int cntw = (nchunk > 2) ? $clog2(nchunk) : 1;
    localparam logic signed [accw-1:0] acc_max = {1'b0, {(accw-1){1'b1}}};
    localparam logic signed [accw-1:0] acc_min = {1'b1, {(accw-1){1'b0}}};
    localparam logic signed [bitw-1:0] out_max = {1'b0, {(bitw-1){1'b1}}};
    localparam logic signed [bitw-1:0] out_min = {1'b1, {(bitw-1){1'b0}}};

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t                  state_reg;
    logic signed [accw-1:0]  acc_reg;
    logic [cntw-1:0]         cnt_reg;
    logic                    sat_sticky_reg;
    logic                    out_valid_reg;
    logic [bitw-1:0]         out_data_reg;
    logic                    out_sat_reg;

    logic                    in_ready;
    logic                    accept;
    logic                    emit;
    logic                    last;
    logic [accw:0]           sum_wide;
    logic                    acc_clip;
    logic signed [accw-1:0]  sum_sat;
    logic signed [accw-1:0]  shifted;
    logic signed [accw-1:0]  relu_val;
    logic [accw-bitw:0]      hi_bits;
    logic                    out_clip;
    logic [bitw-1:0]         out_next;

    // HOLD always carries acc=0/cnt=0, so a pass-through beat takes the same path as
    // the first beat of a vector in ACCUM.
    always_comb begin
        in_ready = ((state_reg == ACCUM) || bus.out_ready) && !clear;
        accept   = bus.in_valid && in_ready;
        emit     = out_valid_reg && bus.out_ready && !clear;
        last     = (cnt_reg == cntw'(nchunk - 1));

        sum_wide = {acc_reg[accw-1], acc_reg}
                 + {{(accw+1-bitw){bus.in_data[bitw-1]}}, bus.in_data};
        acc_clip = sum_wide[accw] ^ sum_wide[accw-1];
        sum_sat  = acc_clip ? (sum_wide[accw] ? acc_min : acc_max) : sum_wide[accw-1:0];

        shifted  = sum_sat >>> shift;
        relu_val = shifted;
        if (relu != 0 && shifted[accw-1]) begin
            relu_val = '0;
        end

        // Fits in bitw bits only if all bits above the output sign agree with it.
        hi_bits  = relu_val[accw-1:bitw-1];
        out_clip = !((&hi_bits) || !(|hi_bits));
        out_next = out_clip ? (relu_val[accw-1] ? out_min : out_max) : relu_val[bitw-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ACCUM;
            acc_reg        <= '0;
            cnt_reg        <= '0;
            sat_sticky_reg <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_sat_reg    <= 1'b0;
        end else if (clear) begin
            state_reg      <= ACCUM;
            acc_reg        <= '0;
            cnt_reg        <= '0;
            sat_sticky_reg <= 1'b0;
            out_valid_reg  <= 1'b0;
        end else begin
            if (emit) begin
                out_valid_reg <= 1'b0;
                state_reg     <= ACCUM;
            end
            if (accept) begin
                if (last) begin
                    out_data_reg   <= out_next;
                    out_sat_reg    <= sat_sticky_reg | acc_clip | out_clip;
                    out_valid_reg  <= 1'b1;
                    state_reg      <= HOLD;
                    acc_reg        <= '0;
                    cnt_reg        <= '0;
                    sat_sticky_reg <= 1'b0;
                end else begin
                    acc_reg        <= sum_sat;
                    cnt_reg        <= cnt_reg + cntw'(1);
                    sat_sticky_reg <= sat_sticky_reg | acc_clip;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_sat   = out_sat_reg;
endmodule

// File: tb/tb_dot_accum_int.sv
// Directed bench: four accumulator variants share one stimulus stream and each is
// checked against hand-computed results for its own configuration.
module tb_dot_accum_int;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       out_ready = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // if0: defaults, if1: relu, if2: shift=2, if3: accw=10 shift=3 nchunk=5
    dot_accum_int_if #(.bitw(8)) if0();
    dot_accum_int_if #(.bitw(8)) if1();
    dot_accum_int_if #(.bitw(8)) if2();
    dot_accum_int_if #(.bitw(8)) if3();

    assign if0.in_valid = in_valid;  assign if0.in_data = in_data;  assign if0.out_ready = out_ready;
    assign if1.in_valid = in_valid;  assign if1.in_data = in_data;  assign if1.out_ready = out_ready;
    assign if2.in_valid = in_valid;  assign if2.in_data = in_data;  assign if2.out_ready = out_ready;
    assign if3.in_valid = in_valid;  assign if3.in_data = in_data;  assign if3.out_ready = out_ready;

    dot_accum_int #(.bitw(8), .accw(16), .nchunk(4), .shift(0), .relu(0))
        u_dut0 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(if0));
    dot_accum_int #(.bitw(8), .accw(16), .nchunk(4), .shift(0), .relu(1))
        u_dut1 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(if1));
    dot_accum_int #(.bitw(8), .accw(16), .nchunk(4), .shift(2), .relu(0))
        u_dut2 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(if2));
    dot_accum_int #(.bitw(8), .accw(10), .nchunk(5), .shift(3), .relu(0))
        u_dut3 (.clk(clk), .rst_n(rst_n), .clear(clear), .bus(if3));

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic beat(input int d);
        in_valid = 1'b1;
        in_data  = 8'(d);
        #1;
        check("in_ready", int'(if0.in_ready), 1);
        @(negedge clk);
    endtask

    // Four beats back-to-back; no result may appear before the fourth accept.
    task automatic vec(input int a, input int b, input int c, input int d);
        int v[4];
        v = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            beat(v[i]);
            if (i < 3) check("no_early_valid", int'(if0.out_valid), 0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_out_valid", int'(if0.out_valid), 0);
        check("rst_out_data", $signed(if0.out_data), 0);
        check("rst_out_sat", int'(if0.out_sat), 0);
        check("rst_in_ready", int'(if0.in_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

        vec(8, 7, -3, 2);
        check("t1_valid", int'(if0.out_valid), 1);
        check("t1_data", $signed(if0.out_data), 14);
        check("t1_sat", int'(if0.out_sat), 0);

        // First beat overlaps the pending emit (pass-through)
        vec(-10, -20, 5, 3);
        check("t2_data_norelu", $signed(if0.out_data), -22);
        check("t2_data_relu", $signed(if1.out_data), 0);
        check("t2_sat_relu", int'(if1.out_sat), 0);

        vec(127, 127, 127, 127);
        check("t3_data_s0", $signed(if0.out_data), 127);
        check("t3_sat_s0", int'(if0.out_sat), 1);
        check("t3_data_s2", $signed(if2.out_data), 127);
        check("t3_sat_s2", int'(if2.out_sat), 0);

        vec(-128, -128, -128, -128);
        check("t3_neg_data_s2", $signed(if2.out_data), -128);
        check("t3_neg_sat_s2", int'(if2.out_sat), 0);
        check("t3_neg_data_s0", $signed(if0.out_data), -128);
        check("t3_neg_sat_s0", int'(if0.out_sat), 1);

        vec(8, 7, -3, 2);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'd99;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", int'(if0.in_ready), 0);
            check("bp_valid", int'(if0.out_valid), 1);
            check("bp_data", $signed(if0.out_data), 14);
            @(negedge clk);
        end
        out_ready = 1'b1;
        vec(5, 1, 1, 1);
        check("bp_next_data", $signed(if0.out_data), 8);
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_emitted", int'(if0.out_valid), 0);

        beat(50);
        beat(50);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", int'(if0.out_valid), 0);
        check("arst_data", $signed(if0.out_data), 0);
        check("arst_sat", int'(if0.out_sat), 0);
        @(negedge clk);
        rst_n = 1'b1;
        vec(1, 1, 1, 1);
        check("arst_after_data", $signed(if0.out_data), 4);
        check("arst_after_sat", int'(if0.out_sat), 0);
        in_valid = 1'b0;
        @(negedge clk);

        beat(50);
        beat(50);
        clear    = 1'b1;
        in_data  = 8'd50;
        #1;
        check("clr_in_ready", int'(if0.in_ready), 0);
        @(negedge clk);
        clear = 1'b0;
        check("clr_no_valid", int'(if0.out_valid), 0);
        vec(1, 1, 1, 1);
        check("clr_after_data", $signed(if0.out_data), 4);
        check("clr_after_valid", int'(if0.out_valid), 1);

        // Clear while a result is pending drops it and realigns every variant
        in_valid = 1'b0;
        clear    = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_hold_valid", int'(if0.out_valid), 0);

        // 127*5 = 635 saturates a 10-bit accumulator at 511; 511>>>3 = 63
        for (int i = 0; i < 5; i++) begin
            beat(127);
            if (i == 3) check("t6_no_early_valid", int'(if3.out_valid), 0);
        end
        in_valid = 1'b0;
        check("t6_valid", int'(if3.out_valid), 1);
        check("t6_data", $signed(if3.out_data), 63);
        check("t6_sat", int'(if3.out_sat), 1);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
